// File: rtl/demux18_tdm_enable_if.sv
// Link-side signal bundle for the TDM receive demux: serial input side plus
// the rebuilt-frame and status outputs.
`timescale 1ns/1ps

interface demux18_tdm_enable_if #(
  parameter int unsigned DATA_W = 1
);

  localparam int unsigned Y_W = 8 * DATA_W;

  // Serial side (driven toward the demux)
  logic              e;          // active-low enable
  logic [DATA_W-1:0] din;        // serial channel sample
  logic              sync;       // high while slot 0 is on din

  // Demux results
  logic [2:0]        sel;        // current slot index, feeds the mux select
  logic [Y_W-1:0]    y;          // rebuilt 8-channel frame
  logic              valid;      // one-cycle pulse when y updates
  logic              frame_err;  // one-cycle pulse on a framing violation
  logic              locked;     // high while collecting frames
  logic [3:0]        err_cnt;    // saturating count of frame errors

  // Stream source / consumer side
  modport master (
    output e, din, sync,
    input  sel, y, valid, frame_err, locked, err_cnt
  );

  // Demux side
  modport slave (
    input  e, din, sync,
    output sel, y, valid, frame_err, locked, err_cnt
  );

endinterface

// File: rtl/demux18_tdm_enable.sv
// Receive end of an 8:1 TDM link. Owns the slot counter that steers the
// transmitting mux, samples one slot per enabled clock, and rebuilds the
// 8-channel frame with a valid strobe and channel-0 sync checking.
`timescale 1ns/1ps

module demux18_tdm_enable #(
  parameter int unsigned DATA_W = 1,
  parameter bit          STRICT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux18_tdm_enable_if.slave  bus
);

  localparam int unsigned Y_W     = 8 * DATA_W;
  localparam logic [2:0]  SLOT_0  = 3'd0;
  localparam logic [2:0]  SLOT_1  = 3'd1;
  localparam logic [2:0]  SLOT_7  = 3'd7;
  localparam logic [3:0]  ERR_MAX = 4'hF;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                  state;
  logic [2:0]              sel_q;
  logic [6:0][DATA_W-1:0]  shadow_q;   // slots 0..6 of the frame in flight
  logic [Y_W-1:0]          y_q;
  logic                    valid_q;
  logic                    frame_err_q;
  logic [3:0]              err_cnt_q;

  // Error counter increment that sticks at its maximum
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == ERR_MAX) ? v : v + 4'd1;
  endfunction

  // Slot sequencing, frame assembly and framing checks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      sel_q       <= SLOT_0;
      shadow_q    <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      // Strobes are single-cycle; a frozen cycle also keeps them low
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;

      if (!bus.e) begin
        case (state)
          HUNT: begin
            // Wait for a marked slot 0; sel stays parked at 0 meanwhile
            if (bus.sync) begin
              shadow_q[0] <= bus.din;
              sel_q       <= SLOT_1;
              state       <= COLLECT;
            end
          end

          COLLECT: begin
            if (bus.sync && (sel_q != SLOT_0)) begin
              // Early sync: drop the partial frame and restart at slot 0
              frame_err_q <= 1'b1;
              err_cnt_q   <= sat_inc(err_cnt_q);
              shadow_q[0] <= bus.din;
              sel_q       <= SLOT_1;
            end else if ((sel_q == SLOT_0) && !bus.sync && STRICT) begin
              // Missing marker at slot 0: lose lock, capture nothing
              frame_err_q <= 1'b1;
              err_cnt_q   <= sat_inc(err_cnt_q);
              state       <= HUNT;
            end else if (sel_q == SLOT_7) begin
              // Last slot completes the frame straight from din
              y_q     <= {bus.din, shadow_q};
              valid_q <= 1'b1;
              sel_q   <= SLOT_0;
            end else begin
              // Ordinary slot (also slot 0 with sync, or unmarked in lenient mode)
              shadow_q[sel_q] <= bus.din;
              sel_q           <= sel_q + 3'd1;
            end
          end
        endcase
      end
    end
  end

  // Output drive: everything comes straight from registers
  assign bus.sel       = sel_q;
  assign bus.y         = y_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.locked    = (state == COLLECT);
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demux18_tdm_enable.sv
// Bench for demux18_tdm_enable: a strict 1-bit instance and a lenient 4-bit
// instance share one stimulus stream and are checked every clock against
// a slot-level reference model, with directed checks at the key points.
`timescale 1ns/1ps

module tb_demux18_tdm_enable;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux18_tdm_enable_if #(.DATA_W(1)) bus_a ();
  demux18_tdm_enable_if #(.DATA_W(4)) bus_b ();

  demux18_tdm_enable #(.DATA_W(1), .STRICT(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  demux18_tdm_enable #(.DATA_W(4), .STRICT(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = strict/1-bit, 1 = lenient/4-bit
  bit          m_locked [2];
  int          m_slot   [2];
  int          m_sh     [2][8];
  logic [31:0] m_y      [2];
  bit          m_valid  [2];
  bit          m_ferr   [2];
  int          m_err    [2];

  function automatic int wid(input int m);
    return (m == 0) ? 1 : 4;
  endfunction

  // One clock of the link as the receiver should interpret it
  task automatic model_step(input int m, input bit strict, input logic rst,
                            input logic e, input logic sync, input int din);
    logic [31:0] frame;
    int w;
    w = wid(m);
    if (!rst) begin
      m_locked[m] = 0; m_slot[m] = 0; m_y[m] = 0;
      m_valid[m] = 0; m_ferr[m] = 0; m_err[m] = 0;
      for (int k = 0; k < 8; k++) m_sh[m][k] = 0;
      return;
    end
    m_valid[m] = 0;
    m_ferr[m]  = 0;
    if (e) return;
    if (!m_locked[m]) begin
      if (sync) begin
        m_sh[m][0] = din; m_slot[m] = 1; m_locked[m] = 1;
      end
    end else if (sync && m_slot[m] != 0) begin
      m_ferr[m] = 1; m_sh[m][0] = din; m_slot[m] = 1;
    end else if (m_slot[m] == 0 && !sync && strict) begin
      m_ferr[m] = 1; m_locked[m] = 0;
    end else if (m_slot[m] == 7) begin
      frame = 0;
      for (int k = 0; k < 7; k++) frame = frame | (32'(m_sh[m][k]) << (k * w));
      frame = frame | (32'(din) << (7 * w));
      m_y[m] = frame; m_valid[m] = 1; m_slot[m] = 0;
    end else begin
      m_sh[m][m_slot[m]] = din;
      m_slot[m] = m_slot[m] + 1;
    end
    if (m_ferr[m] && m_err[m] < 15) m_err[m] = m_err[m] + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("a.sel",       32'(bus_a.sel),       32'(m_slot[0]));
    chk("a.y",         32'(bus_a.y),         m_y[0]);
    chk("a.valid",     32'(bus_a.valid),     32'(m_valid[0]));
    chk("a.frame_err", 32'(bus_a.frame_err), 32'(m_ferr[0]));
    chk("a.locked",    32'(bus_a.locked),    32'(m_locked[0]));
    chk("a.err_cnt",   32'(bus_a.err_cnt),   32'(m_err[0]));
    chk("b.sel",       32'(bus_b.sel),       32'(m_slot[1]));
    chk("b.y",         32'(bus_b.y),         m_y[1]);
    chk("b.valid",     32'(bus_b.valid),     32'(m_valid[1]));
    chk("b.frame_err", 32'(bus_b.frame_err), 32'(m_ferr[1]));
    chk("b.locked",    32'(bus_b.locked),    32'(m_locked[1]));
    chk("b.err_cnt",   32'(bus_b.err_cnt),   32'(m_err[1]));
  endtask

  // Apply inputs, clock once, advance the model, compare just after the edge
  task automatic step(input logic e, input logic sync, input logic din_a);
    logic [3:0] din_b;
    din_b = {3'($urandom), din_a};
    bus_a.e = e; bus_a.sync = sync; bus_a.din = din_a;
    bus_b.e = e; bus_b.sync = sync; bus_b.din = din_b;
    @(posedge clk);
    model_step(0, 1'b1, rst_n, e, sync, int'(din_a));
    model_step(1, 1'b0, rst_n, e, sync, int'(din_b));
    #1;
    compare_all();
  endtask

  // Eight slots starting at slot 0; optional freeze before slot stall_at
  task automatic frame(input logic [7:0] bits, input bit sync0,
                       input int stall_at, input int stall_len);
    for (int s = 0; s < 8; s++) begin
      if (s == stall_at) begin
        for (int i = 0; i < stall_len; i++) begin
          step(1'b1, 1'($urandom), 1'($urandom));
          chk("stall.sel", 32'(bus_a.sel), 32'(stall_at));
          chk("stall.valid", 32'(bus_a.valid), 32'd0);
        end
      end
      step(1'b0, (s == 0) && sync0, bits[s]);
    end
  endtask

  logic [7:0]  saved_y;
  int          pos;
  logic        rs, re, rsy;

  initial begin
    bus_a.e = 1'b1; bus_a.sync = 1'b0; bus_a.din = '0;
    bus_b.e = 1'b1; bus_b.sync = 1'b0; bus_b.din = '0;

    // Reset, then hunt with no sync
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("rst.y", 32'(bus_a.y), 32'd0);
    chk("rst.err_cnt", 32'(bus_a.err_cnt), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'($urandom));
      chk("hunt.sel", 32'(bus_a.sel), 32'd0);
      chk("hunt.locked", 32'(bus_a.locked), 32'd0);
    end

    // Clean frame 1,0,1,1,0,0,1,0 over slots 0..7
    frame(8'h4D, 1'b1, -1, 0);
    chk("clean.y", 32'(bus_a.y), 32'h4D);
    chk("clean.valid", 32'(bus_a.valid), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("clean.valid_pulse", 32'(bus_a.valid), 32'd0);

    // Different frame, then the clean frame again with a 3-clk freeze at sel=4
    frame(8'hB2, 1'b1, -1, 0);
    chk("other.y", 32'(bus_a.y), 32'hB2);
    frame(8'h4D, 1'b1, 4, 3);
    chk("stall.y", 32'(bus_a.y), 32'h4D);
    chk("stall.valid_end", 32'(bus_a.valid), 32'd1);

    // Early sync at sel=5
    saved_y = bus_a.y;
    step(1'b0, 1'b1, 1'b0);
    for (int s = 1; s < 5; s++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("early.frame_err", 32'(bus_a.frame_err), 32'd1);
    chk("early.err_cnt", 32'(bus_a.err_cnt), 32'd1);
    chk("early.sel", 32'(bus_a.sel), 32'd1);
    chk("early.y_held", 32'(bus_a.y), 32'(saved_y));
    for (int s = 1; s < 8; s++) step(1'b0, 1'b0, 1'(s & 1));
    chk("early.restart_y", 32'(bus_a.y), 32'hAB);
    frame(8'h3C, 1'b1, -1, 0);
    chk("early.next_y", 32'(bus_a.y), 32'h3C);

    // Missing sync at slot 0: strict drops lock, lenient accepts the frame
    step(1'b0, 1'b0, 1'b1);
    chk("miss.a.frame_err", 32'(bus_a.frame_err), 32'd1);
    chk("miss.a.locked", 32'(bus_a.locked), 32'd0);
    chk("miss.a.sel", 32'(bus_a.sel), 32'd0);
    chk("miss.b.frame_err", 32'(bus_b.frame_err), 32'd0);
    chk("miss.b.sel", 32'(bus_b.sel), 32'd1);
    for (int s = 1; s < 8; s++) step(1'b0, 1'b0, 1'b0);
    chk("miss.b.valid", 32'(bus_b.valid), 32'd1);
    chk("miss.a.sel_hunt", 32'(bus_a.sel), 32'd0);
    frame(8'h96, 1'b1, -1, 0);
    chk("relock.y", 32'(bus_a.y), 32'h96);
    chk("relock.locked", 32'(bus_a.locked), 32'd1);

    // Saturation: slot 0 then 18 early syncs
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'($urandom));
    chk("sat.err_cnt", 32'(bus_a.err_cnt), 32'd15);
    chk("sat.b.err_cnt", 32'(bus_b.err_cnt), 32'd15);
    step(1'b0, 1'b1, 1'b0);
    chk("sat.hold", 32'(bus_a.err_cnt), 32'd15);
    rst_n = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    chk("sat.reset", 32'(bus_a.err_cnt), 32'd0);
    chk("sat.reset_locked", 32'(bus_a.locked), 32'd0);
    rst_n = 1'b1;

    // Random traffic: mostly well-framed, with freezes, stray syncs and resets
    pos = 0;
    for (int i = 0; i < 700; i++) begin
      rs  = ($urandom_range(0, 249) != 0);
      re  = ($urandom_range(0, 3) == 0);
      rsy = (pos == 0);
      if ($urandom_range(0, 24) == 0) rsy = ~rsy;
      rst_n = rs;
      step(re, rsy, 1'($urandom));
      if (!rs) pos = 0;
      else if (!re) pos = (pos + 1) % 8;
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
